// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C target.
package i2c_pkg;

  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_CNT_W  = 3;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WR_ACK,
    ST_READ,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_target_if.sv
// Bus lines and client handshake of the I2C target.
interface i2c_target_if;
  import i2c_pkg::*;

  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_oe;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  tx_req;
  logic                  rw;
  logic                  busy;
  logic                  start_det;
  logic                  stop_det;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, rw, busy, start_det, stop_det
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, rw, busy, start_det, stop_det
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one open-drain line with registered level and edge flags.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;

  // Reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      lvl  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      lvl  <= sync[1];
      rise <= sync[1] & ~lvl;
      fall <= ~sync[1] & lvl;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// Byte-level I2C target: address match, ACK generation, write delivery and read fetch.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h50
) (
  input  logic          clk,
  input  logic          rst,
  i2c_target_if.slave   bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl (.clk(clk), .rst(rst), .line(bus.scl_i),
                       .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync u_sda (.clk(clk), .rst(rst), .line(bus.sda_i),
                       .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  i2c_tgt_state_t        state, state_nxt;
  logic [I2C_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [I2C_BYTE_W-1:0] shreg, shreg_nxt;
  logic                  phase, phase_nxt;
  logic                  lead, lead_nxt;
  logic                  sda_oe, sda_oe_nxt;
  logic [I2C_BYTE_W-1:0] rx_data, rx_data_nxt;
  logic                  rx_valid, rx_valid_nxt;
  logic                  tx_req, tx_req_nxt;
  logic                  rw, rw_nxt;
  logic                  busy, busy_nxt;
  logic                  start_det, start_det_nxt;
  logic                  stop_det, stop_det_nxt;

  logic                  bus_start, bus_stop, last_bit, addr_hit;
  logic [I2C_BYTE_W-1:0] byte_in;

  assign bus_start = sda_fall & scl_lvl;
  assign bus_stop  = sda_rise & scl_lvl;
  assign last_bit  = (bit_cnt == 3'd7);
  assign byte_in   = {shreg[I2C_BYTE_W-2:0], sda_lvl};
  assign addr_hit  = (byte_in[I2C_BYTE_W-1:1] == ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      phase     <= 1'b0;
      lead      <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      phase     <= phase_nxt;
      lead      <= lead_nxt;
      sda_oe    <= sda_oe_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      tx_req    <= tx_req_nxt;
      rw        <= rw_nxt;
      busy      <= busy_nxt;
      start_det <= start_det_nxt;
      stop_det  <= stop_det_nxt;
    end
  end

  // phase: second half of an ACK slot, or 8th read bit already clocked.
  always_comb begin
    state_nxt = state;
    if (bus_start) begin
      state_nxt = ST_ADDR;
    end else if (bus_stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR:     if (scl_rise && last_bit) state_nxt = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: if (scl_fall && phase) state_nxt = (rw == I2C_RW_READ) ? ST_READ : ST_WRITE;
        ST_WRITE:    if (scl_rise && last_bit) state_nxt = ST_WR_ACK;
        ST_WR_ACK:   if (scl_fall && phase) state_nxt = ST_WRITE;
        ST_READ:     if (!tx_req && scl_fall && phase) state_nxt = ST_RD_ACK;
        ST_RD_ACK:   if (scl_rise) state_nxt = (sda_lvl == I2C_ACK) ? ST_READ : ST_WAIT_STOP;
        default:     state_nxt = state;
      endcase
    end
  end

  always_comb begin
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    phase_nxt     = phase;
    lead_nxt      = lead;
    sda_oe_nxt    = sda_oe;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    tx_req_nxt    = 1'b0;
    rw_nxt        = rw;
    busy_nxt      = busy;
    start_det_nxt = 1'b0;
    stop_det_nxt  = 1'b0;
    if (bus_start || bus_stop) begin
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
      bit_cnt_nxt   = '0;
      phase_nxt     = 1'b0;
      lead_nxt      = 1'b0;
      start_det_nxt = bus_start;
      stop_det_nxt  = bus_stop;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 3'(1);
          if (last_bit && addr_hit) begin
            rw_nxt   = byte_in[0];
            busy_nxt = 1'b1;
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
          phase_nxt  = ~phase;
          sda_oe_nxt = ~phase;
          if (phase && state == ST_ADDR_ACK && rw == I2C_RW_READ) begin
            tx_req_nxt = 1'b1;
            lead_nxt   = 1'b1;
          end
        end
        ST_WRITE: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 3'(1);
          if (last_bit) begin
            rx_data_nxt  = byte_in;
            rx_valid_nxt = 1'b1;
          end
        end
        ST_READ: begin
          // After the address ACK the first bit must go out in the same SCL-low phase.
          if (tx_req) begin
            if (lead) begin
              sda_oe_nxt = ~bus.tx_data[I2C_BYTE_W-1];
              shreg_nxt  = {bus.tx_data[I2C_BYTE_W-2:0], 1'b0};
              lead_nxt   = 1'b0;
            end else begin
              shreg_nxt = bus.tx_data;
            end
          end else if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 3'(1);
            if (last_bit) phase_nxt = 1'b1;
          end else if (scl_fall) begin
            if (phase) begin
              sda_oe_nxt = 1'b0;
              phase_nxt  = 1'b0;
            end else begin
              sda_oe_nxt = ~shreg[I2C_BYTE_W-1];
              shreg_nxt  = {shreg[I2C_BYTE_W-2:0], 1'b0};
            end
          end
        end
        ST_RD_ACK: if (scl_rise) begin
          if (sda_lvl == I2C_ACK) tx_req_nxt = 1'b1;
          else                    busy_nxt   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe;
  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.tx_req    = tx_req;
  assign bus.rw        = rw;
  assign bus.busy      = busy;
  assign bus.start_det = start_det;
  assign bus.stop_det  = stop_det;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged bus master plus rx/read scoreboards.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int unsigned Q = 10;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m;

  i2c_target_if bus ();
  i2c_target #(.ADDR(7'h50)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int rx_cnt = 0, tx_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic oe_seen = 1'b0;
  logic [7:0] rx_q[$], rd_q[$], tx_src[$];
  logic [7:0] last_rx = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard/responder: pops expected rx bytes, supplies read bytes on tx_req.
  always @(negedge clk) begin
    if (bus.tx_req) begin
      bus.tx_data = (tx_src.size() != 0) ? tx_src.pop_front() : 8'h00;
      rd_q.push_back(bus.tx_data);
    end else begin
      bus.tx_data = 8'hE7;
    end
    if (!rst) begin
      if (bus.tx_req)    tx_cnt++;
      if (bus.start_det) start_cnt++;
      if (bus.stop_det)  stop_cnt++;
      if (bus.sda_oe)    oe_seen = 1'b1;
      if (bus.rx_valid) begin
        rx_cnt++;
        if (rx_q.size() == 0) check("rx_unexpected", 32'(bus.rx_data), 32'hFFFF_FFFF);
        else                  check("rx_data", 32'(bus.rx_data), 32'(rx_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b;  wait_q();
    scl_m = 1'b1; wait_q();
    s = bus.sda_i; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic do_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic do_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_check(input logic ack_bit, input string tag);
    logic [7:0] d;
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(ack_bit, s);
    if (rd_q.size() == 0) check(tag, 32'(d), 32'hFFFF_FFFF);
    else                  check(tag, 32'(d), 32'(rd_q.pop_front()));
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.sda_oe, bus.rx_data, bus.rx_valid, bus.tx_req, bus.rw,
                bus.busy, bus.start_det, bus.stop_det});
  endfunction

  initial begin
    logic ack;
    int s0, p0, r0, t0;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outputs", out_vec(), 32'h0);
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    wait_q();

    // Write 0x3C to 7'h50
    s0 = start_cnt; p0 = stop_cnt; r0 = rx_cnt;
    do_start();
    wr_byte(8'hA0, ack); check("w_addr_ack", 32'(ack), 32'(I2C_ACK));
    check("w_busy", 32'(bus.busy), 32'h1);
    check("w_rw", 32'(bus.rw), 32'h0);
    rx_q.push_back(8'h3C); last_rx = 8'h3C;
    wr_byte(8'h3C, ack); check("w_data_ack", 32'(ack), 32'(I2C_ACK));
    do_stop();
    check("w_rx_cnt", 32'(rx_cnt - r0), 32'd1);
    check("w_start_cnt", 32'(start_cnt - s0), 32'd1);
    check("w_stop_cnt", 32'(stop_cnt - p0), 32'd1);
    check("w_busy_end", 32'(bus.busy), 32'h0);
    check("w_state", 32'(dut.state), 32'(ST_IDLE));
    check("w_rx_hold", 32'(bus.rx_data), 32'h3C);

    // Wrong address 7'h51
    oe_seen = 1'b0; r0 = rx_cnt;
    do_start();
    wr_byte(8'hA2, ack); check("nm_addr_nack", 32'(ack), 32'(I2C_NACK));
    wr_byte(8'h11, ack); check("nm_data_nack", 32'(ack), 32'(I2C_NACK));
    check("nm_state", 32'(dut.state), 32'(ST_WAIT_STOP));
    check("nm_busy", 32'(bus.busy), 32'h0);
    do_stop();
    check("nm_oe_seen", 32'(oe_seen), 32'h0);
    check("nm_rx_cnt", 32'(rx_cnt - r0), 32'd0);
    check("nm_state_end", 32'(dut.state), 32'(ST_IDLE));

    // Read two bytes, ACK then NACK
    tx_src.push_back(8'h96); tx_src.push_back(8'h5A);
    t0 = tx_cnt;
    do_start();
    wr_byte(8'hA1, ack); check("r_addr_ack", 32'(ack), 32'(I2C_ACK));
    check("r_rw", 32'(bus.rw), 32'h1);
    rd_check(I2C_ACK, "r_byte0");
    rd_check(I2C_NACK, "r_byte1");
    check("r_state", 32'(dut.state), 32'(ST_WAIT_STOP));
    check("r_busy", 32'(bus.busy), 32'h0);
    check("r_oe_rel", 32'(bus.sda_oe), 32'h0);
    check("r_tx_cnt", 32'(tx_cnt - t0), 32'd2);
    do_stop();

    // Write then repeated START into a read
    s0 = start_cnt; t0 = tx_cnt;
    tx_src.push_back(8'hC3);
    do_start();
    wr_byte(8'hA0, ack); check("rs_w_ack", 32'(ack), 32'(I2C_ACK));
    check("rs_rw0", 32'(bus.rw), 32'h0);
    rx_q.push_back(8'h01); last_rx = 8'h01;
    wr_byte(8'h01, ack); check("rs_d_ack", 32'(ack), 32'(I2C_ACK));
    do_start();
    check("rs_busy_clr", 32'(bus.busy), 32'h0);
    wr_byte(8'hA1, ack); check("rs_r_ack", 32'(ack), 32'(I2C_ACK));
    check("rs_rw1", 32'(bus.rw), 32'h1);
    rd_check(I2C_NACK, "rs_byte");
    do_stop();
    check("rs_start_cnt", 32'(start_cnt - s0), 32'd2);
    check("rs_tx_cnt", 32'(tx_cnt - t0), 32'd1);
    check("rs_rx_data", 32'(bus.rx_data), 32'(last_rx));

    // STOP in the middle of a written byte
    r0 = rx_cnt;
    do_start();
    wr_byte(8'hA0, ack); check("pb_addr_ack", 32'(ack), 32'(I2C_ACK));
    for (int i = 0; i < 4; i++) bit_xfer(1'(i % 2 == 0), ack);
    do_stop();
    check("pb_rx_cnt", 32'(rx_cnt - r0), 32'd0);
    check("pb_rx_data", 32'(bus.rx_data), 32'(last_rx));
    check("pb_state", 32'(dut.state), 32'(ST_IDLE));

    // Reset while driving a 0 read bit
    tx_src.push_back(8'h00);
    do_start();
    wr_byte(8'hA1, ack); check("rr_addr_ack", 32'(ack), 32'(I2C_ACK));
    begin
      int n = 0;
      while (!bus.sda_oe && n < 20) begin @(negedge clk); n++; end
    end
    check("rr_drive0", 32'(bus.sda_oe), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rr_oe_rel", 32'(bus.sda_oe), 32'h0);
    check("rr_outputs", out_vec(), 32'h0);
    check("rr_state", 32'(dut.state), 32'(ST_IDLE));
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    rd_q.delete(); tx_src.delete();
    wait_q();
    check("rr_idle_outputs", out_vec(), 32'h0);

    check("rx_q_drained", 32'(rx_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
